// File: rtl/sync_pkg.sv
// ---------------------------------------------------------------------------
// sync_pkg
// Shared types and constants for the multi-channel input synchronizer.
//   evt_mode_e      : selects which per-channel condition sets the sticky
//                     event flag (rising edge, falling edge, either edge,
//                     or synchronized level high).
//   SYNC_MIN_STAGES : fewest flops allowed in a synchronizer chain.
// ---------------------------------------------------------------------------
package sync_pkg;

    typedef enum logic [1:0] {
        EVT_RISE,
        EVT_FALL,
        EVT_BOTH,
        EVT_LEVEL
    } evt_mode_e;

    localparam int SYNC_MIN_STAGES = 2;

endpackage

// File: rtl/sync_filt_ch.sv
// ---------------------------------------------------------------------------
// sync_filt_ch
// One channel of the input synchronizer: a STAGES-deep flop chain, an
// optional debounce filter and registered rise/fall pulses.
// Ports:
//   clk      in   clock, all flops on posedge
//   rst      in   synchronous active-high reset
//   sig_in   in   asynchronous level input
//   sig_out  out  synchronized (and filtered) level
//   rise     out  one-cycle pulse in the first cycle sig_out is 1 after 0
//   fall     out  one-cycle pulse in the first cycle sig_out is 0 after 1
// ---------------------------------------------------------------------------
module sync_filt_ch
    import sync_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter int   FILTER  = 0,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_out,
    output logic rise,
    output logic fall
);

    // A chain shorter than the minimum is not a synchronizer at all.
    generate
        if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
            $error("sync_filt_ch: STAGES must be at least 2");
        end
    endgenerate

    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              syn;
    logic              out_nxt;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], sig_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign syn = chain_q[STAGES-1];

    generate
        if (FILTER == 0) begin : g_nofilt
            // Without a filter the last chain stage is the output, and the
            // stage feeding it is the output's next state.
            assign sig_out = syn;
            assign out_nxt = chain_d[STAGES-1];
        end else begin : g_filt
            localparam int             CW       = $clog2(FILTER + 1);
            localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          filt_q, filt_d;

            // The output only follows syn once syn has disagreed with it for
            // FILTER consecutive cycles; any agreement restarts the count.
            always_comb begin
                cnt_d  = '0;
                filt_d = filt_q;
                if (syn != filt_q) begin
                    if (cnt_q == CNT_LAST) begin
                        filt_d = ~filt_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q  <= '0;
                    filt_q <= RST_VAL;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign sig_out = filt_q;
            assign out_nxt = filt_d;
        end
    endgenerate

    // Pulses are computed from the output's next state so they line up with
    // the first cycle of the new level rather than trailing it.
    always_comb begin
        rise_d = out_nxt & ~sig_out;
        fall_d = ~out_nxt & sig_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/sync_ndff_evt.sv
// ---------------------------------------------------------------------------
// sync_ndff_evt
// Multi-channel synchronizer for asynchronous level inputs with sticky
// event flags and a single masked interrupt.
// Ports:
//   clk      in   clock, all flops on posedge
//   rst      in   synchronous active-high reset
//   sig_in   in   [WIDTH] asynchronous level inputs
//   sig_out  out  [WIDTH] synchronized (and filtered) levels
//   rise     out  [WIDTH] one-cycle rising-edge pulses
//   fall     out  [WIDTH] one-cycle falling-edge pulses
//   evt      out  [WIDTH] sticky event flags
//   evt_clr  in   [WIDTH] per-bit clear of evt
//   evt_en   in   [WIDTH] per-bit interrupt enable
//   irq      out  registered OR of enabled event flags
// ---------------------------------------------------------------------------
module sync_ndff_evt
    import sync_pkg::*;
#(
    parameter int        WIDTH    = 4,
    parameter int        STAGES   = 2,
    parameter int        FILTER   = 0,
    parameter logic      RST_VAL  = 1'b0,
    parameter evt_mode_e EVT_MODE = EVT_RISE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] evt,
    input  logic [WIDTH-1:0] evt_clr,
    input  logic [WIDTH-1:0] evt_en,
    output logic             irq
);

    logic [WIDTH-1:0] evt_src;
    logic [WIDTH-1:0] evt_q, evt_d;
    logic             irq_q, irq_d;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            sync_filt_ch #(
                .STAGES  (STAGES),
                .FILTER  (FILTER),
                .RST_VAL (RST_VAL)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .sig_in  (sig_in[i]),
                .sig_out (sig_out[i]),
                .rise    (rise[i]),
                .fall    (fall[i])
            );
        end
    endgenerate

    always_comb begin
        evt_src = '0;
        case (EVT_MODE)
            EVT_RISE:  evt_src = rise;
            EVT_FALL:  evt_src = fall;
            EVT_BOTH:  evt_src = rise | fall;
            EVT_LEVEL: evt_src = sig_out;
            default:   evt_src = '0;
        endcase
    end

    // A new event in the same cycle as a clear keeps the flag set, so an
    // event arriving while software acknowledges the previous one is not lost.
    always_comb begin
        evt_d = evt_src | (evt_q & ~evt_clr);
        irq_d = |(evt_q & evt_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            evt_q <= evt_d;
            irq_q <= irq_d;
        end
    end

    assign evt = evt_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_sync_ndff_evt.sv
// ---------------------------------------------------------------------------
// tb_sync_ndff_evt
// Directed bench for sync_ndff_evt using three instances:
//   a : STAGES=3, FILTER=0, EVT_BOTH  (reset, latency, sticky/irq, toggling)
//   b : STAGES=2, FILTER=4, EVT_RISE  (glitch suppression, filtered latency)
//   c : STAGES=2, FILTER=8, EVT_RISE  (reset in the middle of a filter count)
// ---------------------------------------------------------------------------
module tb_sync_ndff_evt;
    import sync_pkg::*;

    logic clk = 1'b0;
    logic rst;

    logic [3:0] a_in, a_out, a_rise, a_fall, a_evt, a_clr, a_en;
    logic       a_irq;
    logic [3:0] b_in, b_out, b_rise, b_fall, b_evt, b_clr, b_en;
    logic       b_irq;
    logic [3:0] c_in, c_out, c_rise, c_fall, c_evt, c_clr, c_en;
    logic       c_irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_ndff_evt #(
        .WIDTH(4), .STAGES(3), .FILTER(0), .RST_VAL(1'b0), .EVT_MODE(EVT_BOTH)
    ) dut_a (
        .clk(clk), .rst(rst), .sig_in(a_in), .sig_out(a_out), .rise(a_rise),
        .fall(a_fall), .evt(a_evt), .evt_clr(a_clr), .evt_en(a_en), .irq(a_irq)
    );

    sync_ndff_evt #(
        .WIDTH(4), .STAGES(2), .FILTER(4), .RST_VAL(1'b0), .EVT_MODE(EVT_RISE)
    ) dut_b (
        .clk(clk), .rst(rst), .sig_in(b_in), .sig_out(b_out), .rise(b_rise),
        .fall(b_fall), .evt(b_evt), .evt_clr(b_clr), .evt_en(b_en), .irq(b_irq)
    );

    sync_ndff_evt #(
        .WIDTH(4), .STAGES(2), .FILTER(8), .RST_VAL(1'b0), .EVT_MODE(EVT_RISE)
    ) dut_c (
        .clk(clk), .rst(rst), .sig_in(c_in), .sig_out(c_out), .rise(c_rise),
        .fall(c_fall), .evt(c_evt), .evt_clr(c_clr), .evt_en(c_en), .irq(c_irq)
    );

    // Every comparison goes through here.
    task automatic check_output(input string tag, input logic [31:0] got,
                                input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        int n_rise, n_fall, n_both;

        rst   = 1'b1;
        a_in  = '0; a_clr = '0; a_en = 4'b0100;
        b_in  = '0; b_clr = '0; b_en = '0;
        c_in  = '0; c_clr = '0; c_en = '0;

        // ---- reset held three cycles, then ten idle cycles ----
        repeat (3) tick();
        rst = 1'b0;
        check_output("rst_a_out",  {28'd0, a_out},  32'h0);
        check_output("rst_a_edge", {24'd0, a_rise, a_fall}, 32'h0);
        check_output("rst_a_evt",  {28'd0, a_evt},  32'h0);
        check_output("rst_a_irq",  {31'd0, a_irq},  32'h0);
        check_output("rst_bc_out", {24'd0, b_out, c_out}, 32'h0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if ((a_rise | a_fall | a_evt | b_rise | b_fall | c_rise | c_fall) != 0 || a_irq)
                seen++;
        end
        check_output("idle_pulses", seen, 0);

        // ---- latency: STAGES=3, channel 0 ----
        a_in[0] = 1'b1;
        tick();
        check_output("lat_e1_out", {31'd0, a_out[0]}, 32'h0);
        tick();
        check_output("lat_e2_out", {31'd0, a_out[0]}, 32'h0);
        tick();
        check_output("lat_e3_out",  {31'd0, a_out[0]},  32'h1);
        check_output("lat_e3_rise", {31'd0, a_rise[0]}, 32'h1);
        check_output("lat_e3_fall", {31'd0, a_fall[0]}, 32'h0);
        tick();
        check_output("lat_e4_rise", {31'd0, a_rise[0]}, 32'h0);
        check_output("lat_e4_evt",  {31'd0, a_evt[0]},  32'h1);
        // evt[0] is set but masked, so no interrupt
        tick();
        check_output("mask_irq", {31'd0, a_irq}, 32'h0);

        // ---- sticky event and clear on channel 2 ----
        a_in[2] = 1'b1;
        repeat (3) tick();
        check_output("st_rise2", {31'd0, a_rise[2]}, 32'h1);
        tick();
        check_output("st_evt2",     {31'd0, a_evt[2]}, 32'h1);
        check_output("st_irq_lag",  {31'd0, a_irq},    32'h0);
        tick();
        check_output("st_irq_set",  {31'd0, a_irq},    32'h1);
        a_in[2] = 1'b0;
        repeat (3) tick();
        check_output("st_fall2", {31'd0, a_fall[2]}, 32'h1);
        a_clr[2] = 1'b1;
        tick();
        check_output("st_set_wins", {31'd0, a_evt[2]}, 32'h1);
        tick();
        check_output("st_cleared",  {31'd0, a_evt[2]}, 32'h0);
        check_output("st_irq_hold", {31'd0, a_irq},    32'h1);
        a_clr[2] = 1'b0;
        tick();
        check_output("st_irq_clr",  {31'd0, a_irq},    32'h0);

        // ---- toggling channel 3: every 2 cycles, then every cycle ----
        for (int p = 2; p >= 1; p--) begin
            n_rise = 0; n_fall = 0; n_both = 0;
            for (int t = 0; t < 20; t++) begin
                a_in[3] = ~a_in[3];
                for (int w = 0; w < p; w++) begin
                    tick();
                    n_rise += int'(a_rise[3]);
                    n_fall += int'(a_fall[3]);
                    n_both += int'(a_rise[3] & a_fall[3]);
                end
            end
            for (int w = 0; w < 5; w++) begin
                tick();
                n_rise += int'(a_rise[3]);
                n_fall += int'(a_fall[3]);
                n_both += int'(a_rise[3] & a_fall[3]);
            end
            check_output($sformatf("tog_p%0d_rise", p), n_rise, 10);
            check_output($sformatf("tog_p%0d_fall", p), n_fall, 10);
            check_output($sformatf("tog_p%0d_both", p), n_both, 0);
        end

        // ---- glitch filter: FILTER=4, channel 1 ----
        seen = 0;
        b_in[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen += int'(b_out[1] | b_rise[1] | b_evt[1]);
        end
        b_in[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen += int'(b_out[1] | b_rise[1] | b_evt[1]);
        end
        check_output("glitch_supp", seen, 0);
        b_in[1] = 1'b1;
        repeat (5) tick();
        check_output("filt_e5_out",  {31'd0, b_out[1]},  32'h0);
        tick();
        check_output("filt_e6_out",  {31'd0, b_out[1]},  32'h1);
        check_output("filt_e6_rise", {31'd0, b_rise[1]}, 32'h1);
        tick();
        check_output("filt_e7_evt",  {31'd0, b_evt[1]},  32'h1);
        check_output("filt_e7_rise", {31'd0, b_rise[1]}, 32'h0);

        // ---- reset in the middle of a FILTER=8 count ----
        c_in[0] = 1'b1;
        repeat (7) tick();
        check_output("mid_pre_out", {31'd0, c_out[0]}, 32'h0);
        rst     = 1'b1;
        c_in[0] = 1'b0;
        tick();
        rst = 1'b0;
        check_output("mid_rst_out",  {31'd0, c_out[0]},  32'h0);
        check_output("mid_rst_aevt", {28'd0, a_evt},     32'h0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen += int'(c_out[0] | c_rise[0] | c_evt[0]);
        end
        check_output("mid_no_rise", seen, 0);
        c_in[0] = 1'b1;
        repeat (9) tick();
        check_output("mid_e9_out",   {31'd0, c_out[0]},  32'h0);
        tick();
        check_output("mid_e10_out",  {31'd0, c_out[0]},  32'h1);
        check_output("mid_e10_rise", {31'd0, c_rise[0]}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
